// File: rtl/hssi_ets_pkg.sv
// Shared constants and helpers for the egress timestamp fingerprint tracker.
package hssi_ets_pkg;

  localparam int TS_WIDTH      = 96;
  localparam int AVST_FP_WIDTH = 32;

  // True when every returned fingerprint bit at or above 'width' is zero.
  function automatic logic fp_upper_clear(input logic [AVST_FP_WIDTH-1:0] fp,
                                          input int unsigned             width);
    logic [AVST_FP_WIDTH-1:0] mask;
    mask = {AVST_FP_WIDTH{1'b1}} << width;
    return (fp & mask) == '0;
  endfunction

endpackage

// File: rtl/hssi_ets_fp_fifo.sv
// Show-ahead FIFO holding the pending {fp, tag} entries in issue order.
module hssi_ets_fp_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // NOTE: storage has no reset; validity is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/hssi_ets_fp_tracker.sv
// Issues egress-timestamp fingerprints, matches MAC returns against the oldest pending
// request and hands {tag, timestamp} to the consumer with mismatch/timeout/overflow reporting.
module hssi_ets_fp_tracker
  import hssi_ets_pkg::*;
#(
  parameter int FP_WIDTH       = 8,
  parameter int TAG_WIDTH      = 16,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  input  logic [TAG_WIDTH-1:0]       req_tag,
  output logic                       req_ready,
  output logic                       ets_valid,
  output logic [FP_WIDTH-1:0]        ets_fp,
  input  logic                       ts_valid,
  input  logic [TS_WIDTH-1:0]        ts_data,
  input  logic [AVST_FP_WIDTH-1:0]   ts_fp,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TAG_WIDTH-1:0]       out_tag,
  output logic [TS_WIDTH-1:0]        out_ts,
  output logic [$clog2(DEPTH):0]     pending_cnt,
  output logic                       err_mismatch,
  output logic                       err_timeout,
  output logic                       err_overflow
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES);

  typedef struct packed {
    logic [FP_WIDTH-1:0]  fp;
    logic [TAG_WIDTH-1:0] tag;
  } entry_t;

  entry_t                 w_push_entry;
  entry_t                 w_head;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_grant;
  logic                   w_fp_hit;
  logic                   w_match;
  logic                   w_timeout;
  logic                   w_pop;
  logic                   w_out_free;
  logic                   w_load;

  logic                   r_active;
  logic [FP_WIDTH-1:0]    r_fp_cnt;
  logic [TO_W-1:0]        r_to_cnt;
  logic                   r_out_valid;
  logic [TAG_WIDTH-1:0]   r_out_tag;
  logic [TS_WIDTH-1:0]    r_out_ts;
  logic                   r_err_mismatch;
  logic                   r_err_timeout;
  logic                   r_err_overflow;

  hssi_ets_fp_fifo #(
    .WIDTH (FP_WIDTH + TAG_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_grant),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (pending_cnt)
  );

  // Fullness is judged before any same-cycle pop, so a full table never accepts a request.
  assign req_ready    = r_active & ~w_full;
  assign w_grant      = req_valid & req_ready;
  assign ets_valid    = w_grant;
  assign ets_fp       = r_fp_cnt;
  assign w_push_entry = '{fp: r_fp_cnt, tag: req_tag};

  assign w_fp_hit   = (ts_fp[FP_WIDTH-1:0] == w_head.fp) && fp_upper_clear(ts_fp, FP_WIDTH);
  assign w_match    = ts_valid & ~w_empty & w_fp_hit;
  assign w_timeout  = ~w_empty & ~w_match & (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign w_pop      = w_match | w_timeout;
  assign w_out_free = ~r_out_valid | out_ready;
  assign w_load     = w_match & w_out_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active       <= 1'b0;
      r_fp_cnt       <= '0;
      r_to_cnt       <= '0;
      r_out_valid    <= 1'b0;
      r_out_tag      <= '0;
      r_out_ts       <= '0;
      r_err_mismatch <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      r_active <= 1'b1;
      if (w_grant) r_fp_cnt <= r_fp_cnt + FP_WIDTH'(1);

      // The head's age restarts whenever it changes or the table is idle.
      if (w_pop || w_empty) r_to_cnt <= '0;
      else                  r_to_cnt <= r_to_cnt + TO_W'(1);

      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_tag   <= w_head.tag;
        r_out_ts    <= ts_data;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      r_err_mismatch <= ts_valid & ~w_match;
      r_err_timeout  <= w_timeout;
      r_err_overflow <= w_match & ~w_out_free;
    end
  end

  assign out_valid    = r_out_valid;
  assign out_tag      = r_out_tag;
  assign out_ts       = r_out_ts;
  assign err_mismatch = r_err_mismatch;
  assign err_timeout  = r_err_timeout;
  assign err_overflow = r_err_overflow;

endmodule

// File: tb/tb_hssi_ets_fp_tracker.sv
// Self-checking bench for hssi_ets_fp_tracker: directed table, corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_hssi_ets_fp_tracker;

  localparam int FPW   = 4;
  localparam int TAGW  = 16;
  localparam int DEPTH = 16;
  localparam int TO    = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic [TAGW-1:0]   req_tag;
  logic              req_ready;
  logic              ets_valid;
  logic [FPW-1:0]    ets_fp;
  logic              ts_valid;
  logic [95:0]       ts_data;
  logic [31:0]       ts_fp;
  logic              out_valid;
  logic              out_ready;
  logic [TAGW-1:0]   out_tag;
  logic [95:0]       out_ts;
  logic [4:0]        pending_cnt;
  logic              err_mismatch;
  logic              err_timeout;
  logic              err_overflow;

  hssi_ets_fp_tracker #(
    .FP_WIDTH       (FPW),
    .TAG_WIDTH      (TAGW),
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_tag      (req_tag),
    .req_ready    (req_ready),
    .ets_valid    (ets_valid),
    .ets_fp       (ets_fp),
    .ts_valid     (ts_valid),
    .ts_data      (ts_data),
    .ts_fp        (ts_fp),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_tag      (out_tag),
    .out_ts       (out_ts),
    .pending_cnt  (pending_cnt),
    .err_mismatch (err_mismatch),
    .err_timeout  (err_timeout),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending requests as a queue, head age from cycle stamps.
  typedef struct {
    int              fp;
    logic [TAGW-1:0] tag;
  } m_ent_t;

  m_ent_t          m_q[$];
  int              m_fp;
  bit              m_active;
  bit              m_out_valid;
  logic [TAGW-1:0] m_otag;
  logic [95:0]     m_ots;
  bit              m_emm, m_eto, m_eov;
  int              m_cyc = 0;
  int              m_head_start = 0;

  typedef struct {
    bit              rv;
    logic [TAGW-1:0] tag;
    bit              tv;
    logic [31:0]     fp;
    logic [95:0]     data;
    bit              e_rdy;
    bit              e_ev;
    logic [FPW-1:0]  e_fp;
    logic [4:0]      e_pend;
    bit              e_oval;
    logic [TAGW-1:0] e_otag;
    logic [95:0]     e_ots;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): actual %0h required %0h", name, m_cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_fp = 0; m_active = 0; m_out_valid = 0; m_otag = '0; m_ots = '0;
    m_emm = 0; m_eto = 0; m_eov = 0;
    m_head_start = m_cyc;
  endtask

  task automatic model_step();
    bit was_empty, full, grant, match, to_ev, ov;
    was_empty = (m_q.size() == 0);
    full      = (m_q.size() == DEPTH);
    grant     = req_valid && m_active && !full;
    match     = 0;
    if (!was_empty) match = ts_valid && (ts_fp == 32'(m_q[0].fp));
    to_ev     = !match && !was_empty && (m_cyc - m_head_start == TO - 1);
    ov        = 0;
    if (match) begin
      if (!m_out_valid || out_ready) begin
        m_out_valid = 1; m_otag = m_q[0].tag; m_ots = ts_data;
      end else ov = 1;
    end else if (out_ready) m_out_valid = 0;
    if (match || to_ev) void'(m_q.pop_front());
    if (grant) begin
      m_q.push_back('{m_fp, req_tag});
      m_fp = (m_fp + 1) % (1 << FPW);
    end
    m_emm = ts_valid && !match; m_eto = to_ev; m_eov = ov;
    m_active = 1;
    m_cyc++;
    if (match || to_ev || was_empty) m_head_start = m_cyc;
  endtask

  task automatic compare_model();
    bit rdy;
    rdy = m_active && (m_q.size() < DEPTH);
    check("req_ready", req_ready, rdy);
    check("ets_valid", ets_valid, req_valid && rdy);
    check("ets_fp", ets_fp, m_fp);
    check("pending_cnt", pending_cnt, m_q.size());
    check("out_valid", out_valid, m_out_valid);
    if (m_out_valid) begin
      check("out_tag", out_tag, m_otag);
      check("out_ts", out_ts, m_ots);
    end
    check("err_mismatch", err_mismatch, m_emm);
    check("err_timeout", err_timeout, m_eto);
    check("err_overflow", err_overflow, m_eov);
  endtask

  task automatic drive(input bit rv, input logic [TAGW-1:0] tag, input bit tv,
                       input logic [31:0] fp, input logic [95:0] data, input bit ordy);
    req_valid = rv; req_tag = tag; ts_valid = tv; ts_fp = fp; ts_data = data; out_ready = ordy;
  endtask

  task automatic sample();
    @(negedge clk);
    compare_model();
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cycle(input bit rv, input logic [TAGW-1:0] tag, input bit tv,
                          input logic [31:0] fp, input logic [95:0] data, input bit ordy);
    drive(rv, tag, tv, fp, data, ordy);
    sample();
    advance();
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_req_ready"}, req_ready, 0);
    check({pfx, "_ets_valid"}, ets_valid, 0);
    check({pfx, "_ets_fp"}, ets_fp, 0);
    check({pfx, "_out_valid"}, out_valid, 0);
    check({pfx, "_out_tag"}, out_tag, 0);
    check({pfx, "_out_ts"}, out_ts, 0);
    check({pfx, "_pending"}, pending_cnt, 0);
    check({pfx, "_errs"}, {err_mismatch, err_timeout, err_overflow}, 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(0, '0, 0, '0, '0, 1);
    model_reset();
    @(negedge clk);
    check_all_zero("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, '0, 0, '0, '0, 1);
    sample();
    check("rel_req_ready_pre_edge", req_ready, 0);
    advance();
    drive(0, '0, 0, '0, '0, 1);
    sample();
    check("rel_req_ready_first_cycle", req_ready, 1);
    advance();
  endtask

  function automatic vec_t mk(bit rv, logic [TAGW-1:0] tag, bit tv, logic [31:0] fp,
                              logic [95:0] data, bit e_rdy, bit e_ev, logic [FPW-1:0] e_fp,
                              logic [4:0] e_pend, bit e_oval, logic [TAGW-1:0] e_otag,
                              logic [95:0] e_ots);
    vec_t v;
    v = '{rv, tag, tv, fp, data, e_rdy, e_ev, e_fp, e_pend, e_oval, e_otag, e_ots};
    return v;
  endfunction

  function automatic logic [95:0] rnd96();
    return {$urandom, $urandom, $urandom};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[8];
    logic [95:0] d1;
    int          prev_fp;
    bit          wrapped;

    vecs[0] = mk(1, 'hA1, 0, 0, '0,      1, 1, 0, 0, 0, '0,   '0);
    vecs[1] = mk(1, 'hA2, 0, 0, '0,      1, 1, 1, 1, 0, '0,   '0);
    vecs[2] = mk(1, 'hA3, 0, 0, '0,      1, 1, 2, 2, 0, '0,   '0);
    vecs[3] = mk(0, '0,   1, 0, 'h100,   1, 0, 3, 3, 0, '0,   '0);
    vecs[4] = mk(0, '0,   1, 1, 'h200,   1, 0, 3, 2, 1, 'hA1, 'h100);
    vecs[5] = mk(0, '0,   1, 2, 'h300,   1, 0, 3, 1, 1, 'hA2, 'h200);
    vecs[6] = mk(0, '0,   0, 0, '0,      1, 0, 3, 0, 1, 'hA3, 'h300);
    vecs[7] = mk(0, '0,   0, 0, '0,      1, 0, 3, 0, 0, '0,   '0);

    rst_n = 1'b0;
    drive(0, '0, 0, '0, '0, 1);
    repeat (2) @(posedge clk);
    apply_reset();

    // In-order issue and return with back-to-back output reloads.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].rv, vecs[i].tag, vecs[i].tv, vecs[i].fp, vecs[i].data, 1);
      sample();
      check($sformatf("t1_req_ready[%0d]", i), req_ready, vecs[i].e_rdy);
      check($sformatf("t1_ets_valid[%0d]", i), ets_valid, vecs[i].e_ev);
      check($sformatf("t1_ets_fp[%0d]", i), ets_fp, vecs[i].e_fp);
      check($sformatf("t1_pending[%0d]", i), pending_cnt, vecs[i].e_pend);
      check($sformatf("t1_out_valid[%0d]", i), out_valid, vecs[i].e_oval);
      if (vecs[i].e_oval) begin
        check($sformatf("t1_out_tag[%0d]", i), out_tag, vecs[i].e_otag);
        check($sformatf("t1_out_ts[%0d]", i), out_ts, vecs[i].e_ots);
      end
      advance();
    end

    // Fill to full, then one match (on the head's last cycle before expiry) frees a slot.
    for (int i = 0; i < DEPTH; i++) do_cycle(1, TAGW'('hB00 + i), 0, '0, '0, 1);
    drive(1, 'hBFF, 1, 32'(m_q[0].fp), 96'hB0B0, 1);
    sample();
    check("t2_req_ready_full", req_ready, 0);
    check("t2_ets_valid_full", ets_valid, 0);
    check("t2_pending_full", pending_cnt, DEPTH);
    advance();
    drive(0, '0, 0, '0, '0, 1);
    sample();
    check("t2_req_ready_freed", req_ready, 1);
    check("t2_pending_after_pop", pending_cnt, DEPTH - 1);
    check("t2_no_timeout", err_timeout, 0);
    check("t2_out_tag", out_tag, 'hB00);
    advance();
    for (int i = 0; i < DEPTH - 1; i++) do_cycle(0, '0, 1, 32'(m_q[0].fp), rnd96(), 1);

    // Mismatches: wrong fp, non-zero upper bits, and a return with the table empty.
    do_cycle(1, 'hC1, 0, '0, '0, 1);
    drive(0, '0, 1, 32'((m_q[0].fp + 5) % 16), 96'h55, 1);
    sample(); advance();
    drive(0, '0, 1, 32'h10 | 32'(m_q[0].fp), 96'h66, 1);
    sample();
    check("t3_mismatch_fp", err_mismatch, 1);
    check("t3_no_pop_fp", pending_cnt, 1);
    check("t3_no_out_fp", out_valid, 0);
    advance();
    drive(0, '0, 1, 32'(m_q[0].fp), 96'h77, 1);
    sample();
    check("t3_mismatch_upper", err_mismatch, 1);
    check("t3_no_pop_upper", pending_cnt, 1);
    advance();
    drive(0, '0, 1, 32'h3, 96'h88, 1);
    sample();
    check("t3_match_out", out_valid, 1);
    check("t3_match_ts", out_ts, 96'h77);
    check("t3_match_no_err", err_mismatch, 0);
    check("t3_empty", pending_cnt, 0);
    advance();
    drive(0, '0, 0, '0, '0, 1);
    sample();
    check("t3_mismatch_empty", err_mismatch, 1);
    advance();

    // Timeout: one request with no return expires exactly TO cycles after the push.
    do_cycle(1, 'hD1, 0, '0, '0, 1);
    for (int k = 1; k <= TO + 1; k++) begin
      drive(0, '0, 0, '0, '0, 1);
      sample();
      check($sformatf("t4_err_timeout[%0d]", k), err_timeout, k == TO + 1);
      check($sformatf("t4_pending[%0d]", k), pending_cnt, (k == TO + 1) ? 0 : 1);
      advance();
    end
    // A match on the expiry cycle wins over the timeout.
    do_cycle(1, 'hD2, 0, '0, '0, 1);
    for (int k = 1; k < TO; k++) do_cycle(0, '0, 0, '0, '0, 1);
    do_cycle(0, '0, 1, 32'(m_q[0].fp), 96'hD2D2, 1);
    drive(0, '0, 0, '0, '0, 1);
    sample();
    check("t4_late_match_out", out_valid, 1);
    check("t4_late_match_tag", out_tag, 'hD2);
    check("t4_late_match_no_to", err_timeout, 0);
    check("t4_late_match_pend", pending_cnt, 0);
    advance();

    // Output register held while the consumer stalls; second result overflows.
    do_cycle(1, 'hE1, 0, '0, '0, 0);
    do_cycle(1, 'hE2, 0, '0, '0, 0);
    d1 = 96'hE1E1_0000_1111;
    do_cycle(0, '0, 1, 32'(m_q[0].fp), d1, 0);
    do_cycle(0, '0, 1, 32'(m_q[0].fp), 96'hE2E2, 0);
    drive(0, '0, 0, '0, '0, 0);
    sample();
    check("t5_overflow", err_overflow, 1);
    check("t5_hold_tag", out_tag, 'hE1);
    check("t5_hold_ts", out_ts, d1);
    check("t5_both_popped", pending_cnt, 0);
    advance();
    drive(0, '0, 0, '0, '0, 1);
    sample();
    check("t5_still_held", out_tag, 'hE1);
    check("t5_single_pulse", err_overflow, 0);
    advance();
    do_cycle(0, '0, 0, '0, '0, 1);

    // Fingerprint wrap with interleaved matches.
    prev_fp = -1;
    wrapped = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1, TAGW'('hF00 + i), 0, '0, '0, 1);
      sample();
      if (prev_fp == 15 && ets_fp == 0) wrapped = 1;
      prev_fp = int'(ets_fp);
      advance();
      do_cycle(0, '0, 1, 32'(m_q[0].fp), rnd96(), 1);
    end
    check("t6_fp_wrapped", wrapped, 1);

    // Reset in the middle of traffic with a held result and a pending error pulse.
    do_cycle(1, 'h7A1, 0, '0, '0, 0);
    do_cycle(1, 'h7A2, 0, '0, '0, 0);
    do_cycle(0, '0, 1, 32'(m_q[0].fp), rnd96(), 0);
    do_cycle(1, 'h7A3, 1, 32'hFF, rnd96(), 0);
    drive(1, 'h7A4, 1, 32'(m_q[0].fp), rnd96(), 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_all_zero("midrst");
    compare_model();
    apply_reset();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      bit          rv, tv, ordy;
      logic [31:0] fp;
      rv   = ($urandom_range(0, 99) < 50);
      tv   = ($urandom_range(0, 99) < 45);
      ordy = ($urandom_range(0, 99) < 70);
      fp   = 32'($urandom_range(0, 15));
      if (m_q.size() > 0 && $urandom_range(0, 99) < 80) fp = 32'(m_q[0].fp);
      if ($urandom_range(0, 99) < 5) fp = fp | (32'h1 << $urandom_range(FPW, 31));
      do_cycle(rv, TAGW'($urandom), tv, fp, rnd96(), ordy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
